// File: rtl/flexbex_cx_unit.sv
// CX responder: accepts one custom instruction at a time and runs either a bit-serial
// operation (POPCNT/CLZ/BREV/MULLU) or a single-cycle accumulator operation.
module flexbex_cx_unit #(
  parameter int unsigned STEP_BITS = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cx_req_valid_i,
  output logic        cx_req_ready_o,
  input  logic [6:0]  cx_opcode_i,
  input  logic [2:0]  cx_funct3_i,
  input  logic [31:0] cx_op_a_i,
  input  logic [31:0] cx_op_b_i,
  output logic        cx_rsp_valid_o,
  input  logic        cx_rsp_ready_i,
  output logic [31:0] cx_rsp_result_o,
  output logic        cx_rsp_error_o,
  input  logic        cx_kill_i,
  output logic        busy_o
);

  localparam int unsigned ITER     = 32 / STEP_BITS;
  localparam logic [4:0]  CNT_INIT = 5'(ITER - 1);
  localparam logic [6:0]  OPCODE_CX_REG = 7'h0b;
  localparam logic [6:0]  OPCODE_CX_IMM = 7'h2b;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_e;
  typedef enum logic [2:0] {
    F_POPCNT  = 3'b000,
    F_CLZ     = 3'b001,
    F_BREV    = 3'b010,
    F_MULLU   = 3'b011,
    F_ACC_ADD = 3'b100,
    F_ACC_RD  = 3'b101
  } funct3_e;

  state_e      r_state, w_state_nxt;
  logic [2:0]  r_funct3;
  logic [4:0]  r_cnt;
  logic [31:0] r_a, r_b, r_res, r_acc, r_acc_nxt;
  logic        r_err, r_acc_wr, r_clz_found;

  logic        w_accept, w_legal, w_iter, w_commit, w_clz_found;
  logic [31:0] w_single_res, w_res_step, w_a_step, w_b_step;

  assign cx_req_ready_o  = (r_state == S_IDLE) && !cx_kill_i;
  assign cx_rsp_valid_o  = (r_state == S_RESP);
  assign cx_rsp_result_o = r_res;
  assign cx_rsp_error_o  = r_err;
  assign busy_o          = (r_state != S_IDLE);

  assign w_accept = cx_req_valid_i && cx_req_ready_o;
  assign w_legal  = ((cx_opcode_i == OPCODE_CX_REG) || (cx_opcode_i == OPCODE_CX_IMM)) &&
                    (cx_funct3_i <= 3'd5);
  assign w_iter   = w_legal && !cx_funct3_i[2];
  // The accumulator only changes once the core has actually taken the response.
  assign w_commit = (r_state == S_RESP) && cx_rsp_ready_i && !cx_kill_i && r_acc_wr;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    w_single_res = '0;
    if (w_legal && (cx_funct3_i == F_ACC_ADD)) w_single_res = r_acc + cx_op_a_i;
    else if (w_legal && (cx_funct3_i == F_ACC_RD)) w_single_res = r_acc;
  end

  // One BUSY step: consume STEP_BITS bits of the shifting operand(s).
  always_comb begin
    w_res_step  = r_res;
    w_a_step    = r_a;
    w_b_step    = r_b;
    w_clz_found = r_clz_found;
    case (r_funct3)
      F_POPCNT: begin
        for (int i = 0; i < STEP_BITS; i++) w_res_step = w_res_step + 32'(r_a[i]);
        w_a_step = r_a >> STEP_BITS;
      end
      F_CLZ: begin
        for (int i = 0; i < STEP_BITS; i++) begin
          if (!w_clz_found) begin
            if (r_a[31-i]) w_clz_found = 1'b1;
            else           w_res_step  = w_res_step + 32'd1;
          end
        end
        w_a_step = r_a << STEP_BITS;
      end
      F_BREV: begin
        w_res_step = r_res << STEP_BITS;
        for (int i = 0; i < STEP_BITS; i++) w_res_step[STEP_BITS-1-i] = r_a[i];
        w_a_step = r_a >> STEP_BITS;
      end
      F_MULLU: begin
        for (int i = 0; i < STEP_BITS; i++) begin
          if (r_b[i]) w_res_step = w_res_step + (r_a << i);
        end
        w_a_step = r_a << STEP_BITS;
        w_b_step = r_b >> STEP_BITS;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_iter ? S_BUSY : S_RESP;
      S_BUSY:  if (r_cnt == '0) w_state_nxt = S_RESP;
      S_RESP:  if (cx_rsp_ready_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (cx_kill_i) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values, independent of statement order.
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_funct3    <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_err       <= 1'b0;
      r_acc       <= '0;
      r_acc_nxt   <= '0;
      r_acc_wr    <= 1'b0;
      r_clz_found <= 1'b0;
    end else begin
      if (w_accept) begin
        r_funct3    <= cx_funct3_i;
        r_a         <= cx_op_a_i;
        r_b         <= cx_op_b_i;
        r_cnt       <= CNT_INIT;
        r_clz_found <= 1'b0;
        r_res       <= w_single_res;
        r_err       <= !w_legal;
        r_acc_wr    <= w_legal && cx_funct3_i[2];
        r_acc_nxt   <= (cx_funct3_i == F_ACC_ADD) ? w_single_res : '0;
      end else if (r_state == S_BUSY) begin
        r_res       <= w_res_step;
        r_a         <= w_a_step;
        r_b         <= w_b_step;
        r_clz_found <= w_clz_found;
        r_cnt       <= r_cnt - 5'd1;
      end
      if (w_commit) r_acc <= r_acc_nxt;
    end
  end

endmodule

// File: tb/tb_flexbex_cx_unit.sv
// Scoreboard bench for flexbex_cx_unit: instance 0 uses STEP_BITS=1, instance 1 STEP_BITS=4.
module tb_flexbex_cx_unit;

  localparam int LAT1 = 33;
  localparam int LAT4 = 9;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_error, kill, busy;
  logic [6:0]  opcode     [2];
  logic [2:0]  funct3     [2];
  logic [31:0] op_a       [2];
  logic [31:0] op_b       [2];
  logic [31:0] rsp_result [2];

  always #5 clk = ~clk;

  flexbex_cx_unit #(.STEP_BITS(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n),
    .cx_req_valid_i(req_valid[0]), .cx_req_ready_o(req_ready[0]),
    .cx_opcode_i(opcode[0]), .cx_funct3_i(funct3[0]),
    .cx_op_a_i(op_a[0]), .cx_op_b_i(op_b[0]),
    .cx_rsp_valid_o(rsp_valid[0]), .cx_rsp_ready_i(rsp_ready[0]),
    .cx_rsp_result_o(rsp_result[0]), .cx_rsp_error_o(rsp_error[0]),
    .cx_kill_i(kill[0]), .busy_o(busy[0])
  );

  flexbex_cx_unit #(.STEP_BITS(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n),
    .cx_req_valid_i(req_valid[1]), .cx_req_ready_o(req_ready[1]),
    .cx_opcode_i(opcode[1]), .cx_funct3_i(funct3[1]),
    .cx_op_a_i(op_a[1]), .cx_op_b_i(op_b[1]),
    .cx_rsp_valid_o(rsp_valid[1]), .cx_rsp_ready_i(rsp_ready[1]),
    .cx_rsp_result_o(rsp_result[1]), .cx_rsp_error_o(rsp_error[1]),
    .cx_kill_i(kill[1]), .busy_o(busy[1])
  );

  typedef struct {
    logic [31:0] res;
    logic        err;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t       sb_q [2][$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [1:0] seen = '0;
  logic [1:0] hs_prev = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented response against the head of the queue.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (hs_prev[k]) begin
          hs_prev[k] <= 1'b0;
          check($sformatf("u%0d_req_ready_after_hs", k), 32'(req_ready[k]), 32'd1);
        end
        if (rsp_valid[k] && (sb_q[k].size() > 0)) begin
          if (!seen[k]) begin
            seen[k] <= 1'b1;
            check($sformatf("u%0d_latency", k), 32'(cyc - sb_q[k][0].acc_cyc + 1),
                  32'(sb_q[k][0].lat));
          end
          check($sformatf("u%0d_result", k), rsp_result[k], sb_q[k][0].res);
          check($sformatf("u%0d_error", k), 32'(rsp_error[k]), 32'(sb_q[k][0].err));
          check($sformatf("u%0d_req_ready_in_resp", k), 32'(req_ready[k]), 32'd0);
          if (rsp_ready[k] && !kill[k]) begin
            void'(sb_q[k].pop_front());
            seen[k]    <= 1'b0;
            hs_prev[k] <= 1'b1;
          end
        end else if (rsp_valid[k] && rsp_ready[k] && !kill[k]) begin
          check($sformatf("u%0d_unexpected_rsp", k), 32'(rsp_valid[k]), 32'd0);
        end
      end
    end
  end

  // Issue one request; all driver tasks start and end 1 time unit after a rising edge.
  task automatic send(input int k, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] b, input logic push,
                      input logic [31:0] eres, input logic eerr, input int elat);
    int n = 0;
    opcode[k] = op; funct3[k] = f3; op_a[k] = a; op_b[k] = b;
    req_valid[k] = 1'b1;
    @(negedge clk);
    while (!req_ready[k] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready[k]) begin
      check($sformatf("u%0d_accept_timeout", k), 32'(req_ready[k]), 32'd1);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    if (push) sb_q[k].push_back('{eres, eerr, elat, cyc});
  endtask

  task automatic drain(input int k);
    int n = 0;
    while ((sb_q[k].size() != 0 || rsp_valid[k]) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      check($sformatf("u%0d_drain_timeout", k), 32'(sb_q[k].size()), 32'd0);
      sb_q[k].delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_reset(input int k, input string tag);
    check($sformatf("%s_u%0d_req_ready", tag, k), 32'(req_ready[k]), 32'd1);
    check($sformatf("%s_u%0d_rsp_valid", tag, k), 32'(rsp_valid[k]), 32'd0);
    check($sformatf("%s_u%0d_result", tag, k), rsp_result[k], 32'd0);
    check($sformatf("%s_u%0d_error", tag, k), 32'(rsp_error[k]), 32'd0);
    check($sformatf("%s_u%0d_busy", tag, k), 32'(busy[k]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n_seen;
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    kill      = '0;
    for (int k = 0; k < 2; k++) begin
      opcode[k] = '0; funct3[k] = '0; op_a[k] = '0; op_b[k] = '0;
    end
    #12;
    chk_reset(0, "por");
    chk_reset(1, "por");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bit-serial ops, STEP_BITS=1
    send(0, 7'h0b, 3'b000, 32'hF0F0_0001, 32'h0, 1'b1, 32'd9, 1'b0, LAT1);          drain(0);
    send(0, 7'h0b, 3'b001, 32'h0000_0000, 32'h0, 1'b1, 32'd32, 1'b0, LAT1);         drain(0);
    send(0, 7'h2b, 3'b001, 32'h0000_8000, 32'h0, 1'b1, 32'd16, 1'b0, LAT1);         drain(0);
    send(0, 7'h0b, 3'b010, 32'h0000_0001, 32'h0, 1'b1, 32'h8000_0000, 1'b0, LAT1);  drain(0);
    send(0, 7'h0b, 3'b011, 32'h0001_0003, 32'd5, 1'b1, 32'h0005_000F, 1'b0, LAT1);  drain(0);
    send(0, 7'h2b, 3'b011, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 1'b0, LAT1);  drain(0);

    // STEP_BITS=4
    send(1, 7'h0b, 3'b011, 32'h0001_0003, 32'd5, 1'b1, 32'h0005_000F, 1'b0, LAT4);  drain(1);
    send(1, 7'h0b, 3'b011, 32'hFFFF_FFFF, 32'd2, 1'b1, 32'hFFFF_FFFE, 1'b0, LAT4);  drain(1);
    send(1, 7'h0b, 3'b000, 32'hF0F0_0001, 32'h0, 1'b1, 32'd9, 1'b0, LAT4);          drain(1);
    send(1, 7'h0b, 3'b010, 32'h0000_0001, 32'h0, 1'b1, 32'h8000_0000, 1'b0, LAT4);  drain(1);
    send(1, 7'h0b, 3'b001, 32'h0000_8000, 32'h0, 1'b1, 32'd16, 1'b0, LAT4);         drain(1);

    // Accumulator, 1-cycle latency, commit on handshake
    send(0, 7'h0b, 3'b100, 32'd5, 32'h0, 1'b1, 32'd5, 1'b0, 1);                     drain(0);
    send(0, 7'h0b, 3'b100, 32'hFFFF_FFFE, 32'h0, 1'b1, 32'd3, 1'b0, 1);             drain(0);
    send(0, 7'h0b, 3'b101, 32'h0, 32'h0, 1'b1, 32'd3, 1'b0, 1);                     drain(0);
    send(0, 7'h0b, 3'b101, 32'h0, 32'h0, 1'b1, 32'd0, 1'b0, 1);                     drain(0);

    // Backpressure: response held for 10 cycles
    rsp_ready[0] = 1'b0;
    send(0, 7'h0b, 3'b000, 32'hFFFF_FFFF, 32'h0, 1'b1, 32'd32, 1'b0, LAT1);
    n_seen = 0;
    while (!rsp_valid[0] && n_seen < 100) begin
      @(posedge clk); #1;
      n_seen++;
    end
    repeat (10) begin @(posedge clk); #1; end
    rsp_ready[0] = 1'b1;
    drain(0);

    // Kill in RESP: acc must keep 0x10
    send(0, 7'h0b, 3'b100, 32'h10, 32'h0, 1'b1, 32'h10, 1'b0, 1);                   drain(0);
    rsp_ready[0] = 1'b0;
    send(0, 7'h0b, 3'b100, 32'd7, 32'h0, 1'b0, 32'd0, 1'b0, 0);
    check("kill_resp_valid_before", 32'(rsp_valid[0]), 32'd1);
    kill[0] = 1'b1;
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    kill[0] = 1'b0;
    check("kill_resp_valid_after", 32'(rsp_valid[0]), 32'd0);
    check("kill_resp_busy_after", 32'(busy[0]), 32'd0);

    // Kill in BUSY cycle 5
    send(0, 7'h0b, 3'b000, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'd0, 1'b0, 0);
    repeat (4) begin @(posedge clk); #1; end
    check("kill_busy_before", 32'(busy[0]), 32'd1);
    kill[0] = 1'b1;
    @(posedge clk); #1;
    kill[0] = 1'b0;
    check("kill_busy_after", 32'(busy[0]), 32'd0);
    n_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (rsp_valid[0]) n_seen++;
    end
    check("kill_busy_no_rsp", 32'(n_seen), 32'd0);
    @(posedge clk); #1;

    // Kill together with a request in IDLE: not accepted
    opcode[0] = 7'h0b; funct3[0] = 3'b100; op_a[0] = 32'd1;
    req_valid[0] = 1'b1;
    kill[0] = 1'b1;
    @(negedge clk);
    check("kill_idle_req_ready", 32'(req_ready[0]), 32'd0);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    kill[0] = 1'b0;
    check("kill_idle_busy", 32'(busy[0]), 32'd0);
    send(0, 7'h0b, 3'b101, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 1);                    drain(0);

    // Illegal opcodes/funct3
    send(0, 7'h5b, 3'b000, 32'h1234_5678, 32'h0, 1'b1, 32'd0, 1'b1, 1);             drain(0);
    send(0, 7'h0b, 3'b110, 32'h1234_5678, 32'h0, 1'b1, 32'd0, 1'b1, 1);             drain(0);
    send(0, 7'h2b, 3'b111, 32'h1234_5678, 32'h0, 1'b1, 32'd0, 1'b1, 1);             drain(0);

    // Async reset mid-BUSY clears acc
    send(0, 7'h0b, 3'b100, 32'h55, 32'h0, 1'b1, 32'h55, 1'b0, 1);                   drain(0);
    send(0, 7'h0b, 3'b000, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'd0, 1'b0, 0);
    repeat (3) begin @(posedge clk); #1; end
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset(0, "midbusy");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 7'h0b, 3'b101, 32'h0, 32'h0, 1'b1, 32'd0, 1'b0, 1);                     drain(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
